// File: rtl/seg_pkg.sv
// Shared constants and a small helper for the segment scan controller.
package seg_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;     // decoder code that lights no segment
  localparam int         N_DIGITS  = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;  // all digits dark (active-low)
  localparam logic [1:0] COLON_IDX = 2'd2;     // colon lives in the hour-units slot

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-DIV prescaler; tick is high during the last count.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap to zero after the last value.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner feeding a registered BCD-to-segment
// decoder. bcd_out leads the anode strobe by one clock so the anode turns on
// in the same cycle the decoder presents that digit's segments.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic        lz_blank,
  input  logic        colon_on,
  output logic [3:0]  bcd_out,
  output logic [3:0]  anode_n,
  output logic        colon_n,
  output logic        frame_start
);

  // The guard window is tracked by a small saturating counter restarted on
  // every slot tick; it equals the scan count for the first GUARD cycles,
  // which is all the blanking decision needs.
  localparam int            GW      = $clog2(GUARD + 2);
  localparam logic [GW-1:0] GUARD_L = GW'(GUARD);
  localparam logic [1:0]    LAST_IX = 2'(N_DIGITS - 1);

  logic scan_tick;
  logic blink_tick;

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (blink_tick)
  );

  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          in_guard;
  logic          phase_q, phase_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          frame_q, frame_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [1:0]    idx_dly_q;
  logic          en_dly_q;
  logic          colon_dly_q;
  logic [3:0]    anode_q, anode_d;
  logic          colon_q, colon_d;

  // Split the frame snapshot into per-digit nibbles.
  logic [3:0] nib [N_DIGITS];
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
    assign nib[gi] = shadow_q[gi*4 +: 4];
  end

  logic [3:0] cur_nib;
  assign cur_nib  = nib[idx_q];
  assign in_guard = (guard_q < GUARD_L);

  // Scan sequencing, frame snapshot and blink phase.
  always_comb begin
    idx_d    = idx_q;
    guard_d  = guard_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    if (scan_tick) begin
      idx_d   = idx_q + 2'd1;
      guard_d = '0;
      if (idx_q == LAST_IX) begin
        // Latch a whole frame at once so a digit never tears mid-scan.
        shadow_d = digits_in;
        frame_d  = 1'b1;
      end
    end else if (in_guard) begin
      guard_d = guard_q + GW'(1);
    end
    if (blink_tick) begin
      phase_d = ~phase_q;
    end
  end

  // Digit code for the decoder, with all blanking reasons folded in.
  always_comb begin
    bcd_d = cur_nib;
    if (!enable || in_guard) begin
      bcd_d = BCD_BLANK;
    end else if (blink_mask[idx_q] && !phase_q) begin
      bcd_d = BCD_BLANK;
    end else if ((idx_q == LAST_IX) && lz_blank && (cur_nib == 4'h0)) begin
      bcd_d = BCD_BLANK;
    end
  end

  // Anode and colon use the one-clock-delayed slot so they match the decoder.
  always_comb begin
    anode_d = ANODE_OFF;
    if (en_dly_q) begin
      anode_d = anode_sel(idx_dly_q);
    end
    colon_d = ~(colon_dly_q & en_dly_q & (idx_dly_q == COLON_IDX));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      guard_q     <= '0;
      phase_q     <= 1'b1;
      shadow_q    <= 16'hFFFF;
      frame_q     <= 1'b0;
      bcd_q       <= BCD_BLANK;
      idx_dly_q   <= '0;
      en_dly_q    <= 1'b0;
      colon_dly_q <= 1'b0;
      anode_q     <= ANODE_OFF;
      colon_q     <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      guard_q     <= guard_d;
      phase_q     <= phase_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      bcd_q       <= bcd_d;
      idx_dly_q   <= idx_q;
      en_dly_q    <= enable;
      colon_dly_q <= colon_on;
      anode_q     <= anode_d;
      colon_q     <= colon_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign anode_n     = anode_q;
  assign colon_n     = colon_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl. Stimulus pushes hand-computed expectations
// (tagged with the edge number after reset release) into a scoreboard; a
// monitor compares them on the falling edge following that rising edge.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 8;
  localparam int GUARD     = 2;
  localparam int BLINK_DIV = 64;
  localparam int R         = 3;   // last edge of the initial reset

  localparam int K_BCD = 0;
  localparam int K_AN  = 1;
  localparam int K_COL = 2;
  localparam int K_FS  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic        lz_blank = 1'b0;
  logic        colon_on = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  anode_n;
  logic        colon_n;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .GUARD     (GUARD),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .digits_in   (digits_in),
    .blink_mask  (blink_mask),
    .lz_blank    (lz_blank),
    .colon_on    (colon_on),
    .bcd_out     (bcd_out),
    .anode_n     (anode_n),
    .colon_n     (colon_n),
    .frame_start (frame_start)
  );

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  task automatic exp_at(input int k, input int kind, input logic [3:0] val, input string name);
    exp_t e;
    e.cyc  = R + k;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_k(input int k);
    while (ec < R + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every falling edge, retire expectations due at this edge.
  initial begin
    exp_t       keep[$];
    logic [3:0] act;
    forever begin
      @(negedge clk);
      keep = {};
      foreach (sb_q[i]) begin
        if (sb_q[i].cyc == ec) begin
          case (sb_q[i].kind)
            K_BCD:   act = bcd_out;
            K_AN:    act = anode_n;
            K_COL:   act = {3'b000, colon_n};
            default: act = {3'b000, frame_start};
          endcase
          checks++;
          if (act !== sb_q[i].val) begin
            errors++;
            $display("FAIL %s k=%0d: got %b, required %b", sb_q[i].name, sb_q[i].cyc - R, act, sb_q[i].val);
          end else begin
            $display("ok   %s k=%0d: %b", sb_q[i].name, sb_q[i].cyc - R, act);
          end
        end else if (sb_q[i].cyc < ec) begin
          checks++;
          errors++;
          $display("FAIL %s k=%0d: never sampled, required %b", sb_q[i].name, sb_q[i].cyc - R, sb_q[i].val);
        end else begin
          keep.push_back(sb_q[i]);
        end
      end
      sb_q = keep;
    end
  end

  logic [3:0] f1_val [4];
  logic [3:0] f2_val [4];
  logic [3:0] an_tab [4];

  initial begin
    f1_val[0] = 4'h4; f1_val[1] = 4'h3; f1_val[2] = 4'h2; f1_val[3] = 4'h1;
    f2_val[0] = 4'h8; f2_val[1] = 4'h7; f2_val[2] = 4'h6; f2_val[3] = 4'h5;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    // Reset values and blank first frame, then frame 1 of 1234.
    exp_at(0, K_BCD, 4'hF, "rst_bcd");
    exp_at(0, K_AN,  4'b1111, "rst_anode");
    exp_at(0, K_COL, 4'h1, "rst_colon");
    exp_at(0, K_FS,  4'h0, "rst_fs");
    exp_at(5,  K_BCD, 4'hF, "f0_blank_d0");
    exp_at(20, K_BCD, 4'hF, "f0_blank_d2");
    exp_at(31, K_FS, 4'h0, "fs_before");
    exp_at(32, K_FS, 4'h1, "fs_pulse");
    exp_at(33, K_FS, 4'h0, "fs_after");
    for (int s = 0; s < 4; s++) begin
      exp_at(32 + 8*s + 1, K_AN,  an_tab[(s + 3) % 4], "f1_anode_prev");
      exp_at(32 + 8*s + 2, K_AN,  an_tab[s], "f1_anode_new");
      exp_at(32 + 8*s + 2, K_BCD, 4'hF, "f1_guard");
      exp_at(32 + 8*s + 3, K_BCD, f1_val[s], "f1_first");
      exp_at(32 + 8*s + 8, K_BCD, f1_val[s], "f1_last");
    end

    wait_k(0);
    rst       = 1'b0;
    enable    = 1'b1;
    digits_in = 16'h1234;

    // Coherence: change mid frame 1; frame 2 shows the new value.
    wait_k(44);
    digits_in = 16'h5678;
    exp_at(46, K_BCD, 4'h3, "coh_keep_d1");
    exp_at(64, K_FS, 4'h1, "fs_frame2");
    for (int s = 0; s < 4; s++) begin
      exp_at(64 + 8*s + 4, K_BCD, f2_val[s], "f2_new");
    end

    // Blink digits 0/1: phase 0 covers frame 3, phase 1 frame 4.
    wait_k(96);
    blink_mask = 4'b0011;
    exp_at(100, K_BCD, 4'hF, "blink_off_d0");
    exp_at(100, K_AN, 4'b1110, "blink_anode");
    exp_at(110, K_BCD, 4'hF, "blink_off_d1");
    exp_at(118, K_BCD, 4'h6, "blink_d2_keep");
    exp_at(126, K_BCD, 4'h5, "blink_d3_keep");
    exp_at(134, K_BCD, 4'h8, "blink_on_d0");
    exp_at(142, K_BCD, 4'h7, "blink_on_d1");

    // Leading-zero blank and colon, shown from frame 6.
    wait_k(160);
    blink_mask = 4'b0000;
    digits_in  = 16'h0905;
    lz_blank   = 1'b1;
    colon_on   = 1'b1;
    exp_at(198, K_BCD, 4'h5, "lz_d0");
    exp_at(206, K_BCD, 4'h0, "lz_d1_zero");
    exp_at(214, K_BCD, 4'h9, "lz_d2");
    exp_at(222, K_BCD, 4'hF, "lz_d3_blank");
    exp_at(209, K_COL, 4'h1, "colon_pre");
    exp_at(210, K_COL, 4'h0, "colon_on_first");
    exp_at(210, K_AN, 4'b1011, "colon_anode");
    exp_at(217, K_COL, 4'h0, "colon_on_last");
    exp_at(218, K_COL, 4'h1, "colon_post");

    wait_k(224);
    lz_blank = 1'b0;
    exp_at(228, K_BCD, 4'h5, "nolz_d0");
    exp_at(252, K_BCD, 4'h0, "nolz_d3_zero");

    // Enable drop mid slot 0 of frame 8.
    wait_k(260);
    enable = 1'b0;
    exp_at(260, K_BCD, 4'h5, "en_before");
    exp_at(261, K_BCD, 4'hF, "en_bcd_dark");
    exp_at(261, K_AN, 4'b1110, "en_anode_lag");
    exp_at(262, K_AN, 4'b1111, "en_anode_dark");
    exp_at(262, K_COL, 4'h1, "en_colon_dark");

    wait_k(270);
    enable = 1'b1;
    exp_at(271, K_BCD, 4'h0, "reen_bcd_d1");
    exp_at(271, K_AN, 4'b1111, "reen_anode_lag");
    exp_at(272, K_AN, 4'b1101, "reen_anode_d1");

    // Reset mid slot 2 (count 5).
    wait_k(277);
    rst = 1'b1;
    exp_at(278, K_BCD, 4'hF, "mrst_bcd");
    exp_at(278, K_AN, 4'b1111, "mrst_anode");
    exp_at(278, K_COL, 4'h1, "mrst_colon");
    exp_at(278, K_FS, 4'h0, "mrst_fs");
    exp_at(279, K_AN, 4'b1111, "mrst_anode_lag");
    exp_at(280, K_AN, 4'b1110, "mrst_idx0");
    exp_at(283, K_BCD, 4'hF, "mrst_blank_d0");
    exp_at(291, K_BCD, 4'hF, "mrst_blank_d1");
    exp_at(309, K_FS, 4'h0, "mrst_fs_before");
    exp_at(310, K_FS, 4'h1, "mrst_fs_pulse");
    exp_at(313, K_BCD, 4'h5, "mrst_f1_d0");

    wait_k(278);
    rst = 1'b0;

    wait_k(278 + 40);
    @(negedge clk);
    #1;
    foreach (sb_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s k=%0d: left unchecked, required %b", sb_q[i].name, sb_q[i].cyc - R, sb_q[i].val);
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit in case the run stalls.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, required completion");
      $fatal(1, "timeout");
    end
  end

endmodule
